// File: rtl/ddr3_write_arbiter_if.sv
// Shared Avalon-MM burst write bus for ddr3_write_arbiter: packed requester side plus controller side.
// slave is the arbiter's view; master is the view of the writers and controller around it.
interface ddr3_write_arbiter_if #(
  parameter int num_requesters = 2,
  parameter int addr_width     = 27,
  parameter int data_width     = 256
);
  logic [num_requesters-1:0]            m_write;
  logic [num_requesters*addr_width-1:0] m_write_address;
  logic [num_requesters*data_width-1:0] m_write_data;
  logic [num_requesters*4-1:0]          m_burstcount;
  logic [num_requesters-1:0]            m_waitrequest;

  logic                  ddr3_write;
  logic [addr_width-1:0] ddr3_write_address;
  logic [data_width-1:0] ddr3_write_data;
  logic [3:0]            ddr3_burstcount;
  logic                  ddr3_waitrequest;

  modport slave (
    input  m_write, m_write_address, m_write_data, m_burstcount,
    output m_waitrequest,
    output ddr3_write, ddr3_write_address, ddr3_write_data, ddr3_burstcount,
    input  ddr3_waitrequest
  );

  modport master (
    output m_write, m_write_address, m_write_data, m_burstcount,
    input  m_waitrequest,
    input  ddr3_write, ddr3_write_address, ddr3_write_data, ddr3_burstcount,
    output ddr3_waitrequest
  );
endinterface

// File: rtl/ddr3_write_arbiter.sv
// Per-burst arbiter sharing one DDR3 Avalon-MM burst write port between several frame writers.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module ddr3_write_arbiter #(
  parameter int num_requesters = 2,
  parameter int burst_len      = 8,
  parameter int addr_width     = 27,
  parameter int data_width     = 256
) (
  input  logic                              ddr3_clk,
  input  logic                              ddr3clk_reset,
  ddr3_write_arbiter_if.slave               bus,
  output logic [$clog2(num_requesters)-1:0] grant_id,
  output logic                              busy
);
  localparam int         GW        = $clog2(num_requesters);
  localparam logic [3:0] BURST_MAX = 4'(burst_len);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant_id;
  logic          r_busy;
  logic [3:0]    r_beat_cnt;
  logic [3:0]    r_blen;

  logic          w_in_burst;
  logic [GW-1:0] w_winner;
  logic [GW-1:0] w_next_ptr;
  logic [3:0]    w_req_bc;
  logic [3:0]    w_req_blen;
  logic [3:0]    w_blen;
  logic          w_accept;
  logic          w_last;

  assign w_in_burst = (r_state == ST_BURST);

  // Controller side is a pure mux of the granted requester; no register stage.
  always_comb begin
    // NOTE: every output gets a default before the conditional override, so no latch is inferred.
    bus.m_waitrequest      = '1;
    bus.ddr3_write         = w_in_burst & bus.m_write[r_grant_id];
    bus.ddr3_write_address = bus.m_write_address[int'(r_grant_id)*addr_width +: addr_width];
    bus.ddr3_write_data    = bus.m_write_data[int'(r_grant_id)*data_width +: data_width];
    bus.ddr3_burstcount    = bus.m_burstcount[int'(r_grant_id)*4 +: 4];
    if (w_in_burst) begin
      bus.m_waitrequest[r_grant_id] = bus.ddr3_waitrequest;
    end
  end

  assign w_req_bc   = bus.m_burstcount[int'(r_grant_id)*4 +: 4];
  assign w_req_blen = (w_req_bc == 4'd0)     ? 4'd1      :
                      (w_req_bc > BURST_MAX) ? BURST_MAX : w_req_bc;
  // Burst length is only sampled on the first beat; later beats use the latched copy.
  assign w_blen     = (r_beat_cnt == 4'd0) ? w_req_blen : r_blen;
  assign w_accept   = bus.ddr3_write & ~bus.ddr3_waitrequest;
  assign w_last     = w_accept && (r_beat_cnt == w_blen - 4'd1);
  assign w_next_ptr = (int'(r_grant_id) == num_requesters - 1) ? '0 : r_grant_id + 1'b1;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_winner = '0;
    for (int i = num_requesters - 1; i >= 0; i--) begin
      if (bus.m_write[i]) w_winner = GW'(i);
    end
  end
`else
  logic [GW-1:0] r_rr_ptr;

  function automatic logic [GW-1:0] rr_pick(input logic [num_requesters-1:0] req,
                                            input logic [GW-1:0]             ptr);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < num_requesters; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_requesters) idx = idx - num_requesters;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_winner = rr_pick(bus.m_write, r_rr_ptr);
`endif

  // NOTE: asynchronous reset drops the FSM to idle at once, so a burst in flight stops forwarding immediately.
  always_ff @(posedge ddr3_clk or posedge ddr3clk_reset) begin
    if (ddr3clk_reset) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_beat_cnt <= '0;
      r_blen     <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (|bus.m_write) begin
            r_grant_id <= w_winner;
            r_busy     <= 1'b1;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            if (r_beat_cnt == 4'd0) r_blen <= w_req_blen;
            if (w_last) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_beat_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
              r_rr_ptr   <= w_next_ptr;
`endif
            end else begin
              r_beat_cnt <= r_beat_cnt + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = r_busy;

`ifdef ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^w_next_ptr;
`endif
endmodule

// File: tb/tb_ddr3_write_arbiter.sv
// Self-checking bench for ddr3_write_arbiter: directed writer programs, a burst-level reference model
// compared every cycle, and literal expectations on grant order, burst lengths and data order.
module tb_ddr3_write_arbiter;
  localparam int N  = 2;
  localparam int AW = 27;
  localparam int DW = 256;
  localparam int BL = 8;

  logic                 ddr3_clk = 1'b0;
  logic                 ddr3clk_reset;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;

  ddr3_write_arbiter_if #(.num_requesters(N), .addr_width(AW), .data_width(DW)) bus ();

  ddr3_write_arbiter #(
    .num_requesters(N), .burst_len(BL), .addr_width(AW), .data_width(DW)
  ) dut (
    .ddr3_clk      (ddr3_clk),
    .ddr3clk_reset (ddr3clk_reset),
    .bus           (bus.slave),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- writer programs (driven after the rising edge) ----------------
  int   prog_bursts[N], prog_beats[N], prog_bc[N], prog_addr[N];
  int   gap_at[N], gap_len_cfg[N], gap_left[N];
  int   beat_idx[N], burst_no[N], total_beats[N];
  logic acc[N];
  bit   bp_en = 1'b0;

  initial begin
    bus.m_write          = '0;
    bus.m_write_address  = '0;
    bus.m_write_data     = '0;
    bus.m_burstcount     = '0;
    bus.ddr3_waitrequest = 1'b0;
    forever begin
      @(negedge ddr3_clk);
      for (int i = 0; i < N; i++) acc[i] = bus.m_write[i] && !bus.m_waitrequest[i];
      @(posedge ddr3_clk);
      #1;
      if (ddr3clk_reset) begin
        for (int i = 0; i < N; i++) begin
          prog_bursts[i] = 0; gap_at[i] = -1; gap_left[i] = 0;
          beat_idx[i] = 0; burst_no[i] = 0;
        end
        bus.m_write          = '0;
        bus.ddr3_waitrequest = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            beat_idx[i]++;
            total_beats[i]++;
            if (beat_idx[i] == gap_at[i]) begin
              gap_left[i] = gap_len_cfg[i];
              gap_at[i]   = -1;
            end
            if (beat_idx[i] == prog_beats[i]) begin
              beat_idx[i] = 0;
              burst_no[i]++;
              prog_bursts[i]--;
            end
          end
          bus.m_write[i] = (prog_bursts[i] > 0) && (gap_left[i] == 0);
          if (gap_left[i] > 0) gap_left[i]--;
          bus.m_write_address[i*AW +: AW] = AW'(prog_addr[i]);
          bus.m_write_data[i*DW +: DW]    = DW'((i << 12) | (burst_no[i] << 8) | beat_idx[i]);
          bus.m_burstcount[i*4 +: 4]      = 4'(prog_bc[i]);
        end
        bus.ddr3_waitrequest = bp_en ? ~bus.ddr3_waitrequest : 1'b0;
      end
    end
  end

  task automatic program_req(input int i, input int bursts, input int beats, input int bc,
                             input int addr, input int gap_after, input int gap_cycles);
    prog_beats[i]  = beats;
    prog_bc[i]     = bc;
    prog_addr[i]   = addr;
    gap_at[i]      = gap_after;
    gap_len_cfg[i] = gap_cycles;
    gap_left[i]    = 0;
    beat_idx[i]    = 0;
    burst_no[i]    = 0;
    total_beats[i] = 0;
    prog_bursts[i] = bursts;
  endtask

  // ---------------- reference model: bursts as grant / remaining-beat bookkeeping ----------------
  bit                md_busy = 1'b0;
  int                md_grant = 0, md_next = 0, md_left = 0, md_beats = 0;
  int                grant_log[$], len_log[$], beat_grant_log[$];
  logic [15:0]       data_log[$];
  logic [AW-1:0]     first_addr_log[$];
  logic [3:0]        first_bc_log[$];

  function automatic int clamp_len(input int bc);
    return (bc == 0) ? 1 : ((bc > BL) ? BL : bc);
  endfunction

  initial begin
    logic [N-1:0] exp_wr;
    bit           exp_write;
    bit           found;
    int           cand;
    forever begin
      @(negedge ddr3_clk);
      if (ddr3clk_reset) begin
        md_busy = 1'b0; md_grant = 0; md_next = 0; md_left = 0; md_beats = 0;
      end
      exp_write = md_busy && bus.m_write[md_grant];
      exp_wr    = '1;
      if (md_busy) exp_wr[md_grant] = bus.ddr3_waitrequest;
      check("busy", busy, md_busy);
      check("grant_id", grant_id, md_grant);
      check("ddr3_write", bus.ddr3_write, exp_write);
      check("m_waitrequest", bus.m_waitrequest, exp_wr);
      if (exp_write) begin
        check("ddr3_write_address", bus.ddr3_write_address, bus.m_write_address[md_grant*AW +: AW]);
        check("ddr3_write_data", bus.ddr3_write_data, bus.m_write_data[md_grant*DW +: DW]);
        check("ddr3_burstcount", bus.ddr3_burstcount, bus.m_burstcount[md_grant*4 +: 4]);
      end
      if (!ddr3clk_reset) begin
        if (!md_busy) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (md_next + k) % N;
`endif
            if (!found && bus.m_write[cand]) begin
              found    = 1'b1;
              md_grant = cand;
            end
          end
          if (found) begin
            md_busy  = 1'b1;
            md_beats = 0;
          end
        end else if (exp_write && !bus.ddr3_waitrequest) begin
          if (md_beats == 0) begin
            md_left = clamp_len(int'(bus.m_burstcount[md_grant*4 +: 4]));
            first_addr_log.push_back(bus.m_write_address[md_grant*AW +: AW]);
            first_bc_log.push_back(bus.m_burstcount[md_grant*4 +: 4]);
          end
          beat_grant_log.push_back(md_grant);
          data_log.push_back(bus.m_write_data[md_grant*DW +: 16]);
          md_beats++;
          md_left--;
          if (md_left == 0) begin
            grant_log.push_back(md_grant);
            len_log.push_back(md_beats);
            md_busy  = 1'b0;
            md_next  = (md_grant + 1) % N;
            md_beats = 0;
          end
        end
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete(); len_log.delete(); beat_grant_log.delete();
    data_log.delete(); first_addr_log.delete(); first_bc_log.delete();
  endtask

  task automatic wait_idle(input string name);
    int cyc  = 0;
    bit done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge ddr3_clk);
      #1;
      cyc++;
      if (prog_bursts[0] == 0 && prog_bursts[1] == 0 && !busy && !md_busy) done = 1'b1;
    end
    check({name, "_done_in_time"}, done, 1'b1);
    repeat (2) @(negedge ddr3_clk);
  endtask

  task automatic do_reset();
    @(posedge ddr3_clk);
    #2 ddr3clk_reset = 1'b1;
    repeat (2) @(posedge ddr3_clk);
    #2 ddr3clk_reset = 1'b0;
    @(negedge ddr3_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2_exp[6];
    int cnt0;
    bit reached;
`ifdef ARB_FIXED_PRIO_EN
    t2_exp = '{0, 0, 0, 1, 1, 1};
`else
    t2_exp = '{0, 1, 0, 1, 0, 1};
`endif
    for (int i = 0; i < N; i++) begin
      prog_bursts[i] = 0; prog_beats[i] = 1; prog_bc[i] = 1; prog_addr[i] = 0;
      gap_at[i] = -1; gap_len_cfg[i] = 0; gap_left[i] = 0;
      beat_idx[i] = 0; burst_no[i] = 0; total_beats[i] = 0;
    end
    ddr3clk_reset = 1'b1;
    repeat (3) @(posedge ddr3_clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_ddr3_write", bus.ddr3_write, 1'b0);
    check("reset_m_waitrequest", bus.m_waitrequest, 2'b11);
    check("reset_grant_id", grant_id, 1'b0);
    #1 ddr3clk_reset = 1'b0;
    @(negedge ddr3_clk);

    // T1: single 8-beat burst from requester 0
    clear_logs();
    program_req(0, 1, 8, 8, 'h100, -1, 0);
    wait_idle("t1");
    check("t1_bursts", grant_log.size(), 1);
    check("t1_grant", grant_log[0], 0);
    check("t1_beats", len_log[0], 8);
    check("t1_addr", first_addr_log[0], 27'h100);
    check("t1_burstcount", first_bc_log[0], 4'd8);

    // T2: contention from reset release, three 8-beat bursts each
    do_reset();
    clear_logs();
    program_req(0, 3, 8, 8, 'h1000, -1, 0);
    program_req(1, 3, 8, 8, 'h2000, -1, 0);
    wait_idle("t2");
    check("t2_bursts", grant_log.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_grant_%0d", k), grant_log[k], t2_exp[k]);
      check($sformatf("t2_beats_%0d", k), len_log[k], 8);
    end

    // T3: alternate-cycle backpressure on a requester 1 burst
    clear_logs();
    bp_en = 1'b1;
    program_req(1, 1, 8, 8, 'h200, -1, 0);
    wait_idle("t3");
    bp_en = 1'b0;
    check("t3_bursts", grant_log.size(), 1);
    check("t3_grant", grant_log[0], 1);
    check("t3_beats", len_log[0], 8);
    for (int k = 0; k < 8; k++) check($sformatf("t3_data_%0d", k), data_log[k], 16'h1000 + 16'(k));

    // T4: requester 0 pauses 5 cycles after beat 3 while requester 1 waits
    clear_logs();
    program_req(0, 1, 8, 8, 'h300, 3, 5);
    program_req(1, 1, 8, 8, 'h400, -1, 0);
    wait_idle("t4");
    check("t4_bursts", grant_log.size(), 2);
    check("t4_first_grant", grant_log[0], 0);
    check("t4_second_grant", grant_log[1], 1);
    check("t4_first_beats", len_log[0], 8);
    cnt0 = 0;
    for (int k = 0; k < 8; k++) if (beat_grant_log[k] == 0) cnt0++;
    check("t4_no_interleave", cnt0, 8);

    // T5: burstcount 0 gives one beat; burstcount 12 is clamped to 8
    clear_logs();
    program_req(0, 1, 1, 0, 'h500, -1, 0);
    wait_idle("t5a");
    program_req(0, 1, 8, 12, 'h600, -1, 0);
    wait_idle("t5b");
    check("t5_bursts", grant_log.size(), 2);
    check("t5_len_bc0", len_log[0], 1);
    check("t5_len_bc12", len_log[1], 8);

    // T6: reset after beat 4 of a requester 1 burst that follows a requester 0 burst
    program_req(0, 1, 8, 8, 'h700, -1, 0);
    wait_idle("t6_pre");
    program_req(1, 1, 8, 8, 'h800, -1, 0);
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(posedge ddr3_clk);
      #2;
      if (total_beats[1] >= 4) reached = 1'b1;
    end
    check("t6_reached_beat4", reached, 1'b1);
    check("t6_busy_before_reset", busy, 1'b1);
    ddr3clk_reset = 1'b1;
    #1;
    check("t6_async_ddr3_write", bus.ddr3_write, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    check("t6_async_waitrequest", bus.m_waitrequest, 2'b11);
    repeat (2) @(posedge ddr3_clk);
    #2 ddr3clk_reset = 1'b0;
    @(negedge ddr3_clk);
    clear_logs();
    program_req(0, 1, 2, 2, 'h900, -1, 0);
    program_req(1, 1, 2, 2, 'hA00, -1, 0);
    wait_idle("t6_post");
    check("t6_bursts", grant_log.size(), 2);
    check("t6_first_grant", grant_log[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
